// File: rtl/traffic_pkg.sv
// Shared types and LED encodings for the intersection phase controller.
// LED heads are {red,yellow,green}, active-low.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b011;
  localparam logic [2:0] YELLOW = 3'b101;
  localparam logic [2:0] GREEN  = 3'b110;
  localparam logic [2:0] DARK   = 3'b111;

  // Returns {ns_head, ew_head} for a state and flash phase.
  function automatic logic [5:0] head_leds(
    input state_t s,
    input logic   flash_ph
  );
    logic [2:0] ns;
    logic [2:0] ew;
    ns = RED;
    ew = RED;
    unique case (s)
      NS_GREEN:  ns = GREEN;
      NS_YELLOW: ns = YELLOW;
      EW_GREEN:  ew = GREEN;
      EW_YELLOW: ew = YELLOW;
      FLASH: begin
        ns = flash_ph ? YELLOW : DARK;
        ew = ns;
      end
      default: ;
    endcase
    return {ns, ew};
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe
// every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div_cnt;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (div_cnt == LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + W'(1);
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-way phase controller: green/yellow/all-red sequencing,
// pedestrian early cut-off and night flashing-yellow mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 5_000_000,
  parameter int T_GREEN     = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_MIN_GREEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] led_north,
  output logic [2:0] led_south,
  output logic [2:0] led_east,
  output logic [2:0] led_west,
  output logic       ped_pending,
  output logic       tick
);

  localparam int TMAX_GY = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int TMAX = (TMAX_GY > T_ALLRED) ? TMAX_GY : T_ALLRED;
  localparam int SEC_W = $clog2(TMAX + 1);

  localparam logic [SEC_W-1:0] LAST_A = SEC_W'(T_ALLRED - 1);
  localparam logic [SEC_W-1:0] LAST_G = SEC_W'(T_GREEN - 1);
  localparam logic [SEC_W-1:0] LAST_Y = SEC_W'(T_YELLOW - 1);
  localparam logic [SEC_W-1:0] MIN_G = SEC_W'(T_MIN_GREEN - 1);

  state_t           state;
  state_t           state_d;
  logic [SEC_W-1:0] sec_cnt;
  logic             flash_ph;
  logic             flash_d;
  logic [2:0]       ns_q;
  logic [2:0]       ew_q;
  logic [2:0]       ns_d;
  logic [2:0]       ew_d;
  logic             green_done;
  logic             changing;
  logic             ped_clr;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign green_done = (sec_cnt == LAST_G) ||
                      (ped_pending && sec_cnt >= MIN_G);
  assign changing   = (state_d != state);
  assign ped_clr    = changing &&
                      (state_d == NS_YELLOW ||
                       state_d == EW_YELLOW ||
                       state_d == FLASH);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ALLRED_A;
    else
      state <= state_d;
  end

  // Next state: only moves on a tick; night mode preempts.
  always_comb begin
    state_d = state;
    if (tick) begin
      if (night_mode && state != FLASH) begin
        state_d = FLASH;
      end else begin
        unique case (state)
          ALLRED_A:  if (sec_cnt == LAST_A) state_d = NS_GREEN;
          NS_GREEN:  if (green_done)        state_d = NS_YELLOW;
          NS_YELLOW: if (sec_cnt == LAST_Y) state_d = ALLRED_B;
          ALLRED_B:  if (sec_cnt == LAST_A) state_d = EW_GREEN;
          EW_GREEN:  if (green_done)        state_d = EW_YELLOW;
          EW_YELLOW: if (sec_cnt == LAST_Y) state_d = ALLRED_A;
          FLASH:     if (!night_mode)       state_d = ALLRED_A;
          default:                          state_d = ALLRED_A;
        endcase
      end
    end
  end

  // Outputs decoded from next state so LEDs track the state edge.
  always_comb begin
    flash_d = 1'b0;
    if (state_d == FLASH) begin
      if (state != FLASH)
        flash_d = 1'b1;
      else
        flash_d = tick ? ~flash_ph : flash_ph;
    end
    {ns_d, ew_d} = head_leds(state_d, flash_d);
  end

  // Seconds-in-phase counter, restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sec_cnt <= '0;
    else if (changing)
      sec_cnt <= '0;
    else if (tick)
      sec_cnt <= sec_cnt + SEC_W'(1);
  end

  // Flash phase and registered LED heads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_ph <= 1'b0;
      ns_q     <= RED;
      ew_q     <= RED;
    end else begin
      flash_ph <= flash_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
    end
  end

  // Pedestrian latch; a new request beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ped_pending <= 1'b0;
    else
      ped_pending <= ped_req | (ped_pending & ~ped_clr);
  end

  assign led_north = ns_q;
  assign led_south = ns_q;
  assign led_east  = ew_q;
  assign led_west  = ew_q;

endmodule
